// File: rtl/seven_seg_mux.sv
// seven_seg_mux: multiplexed 7-segment driver with frame-synced updates, dead time,
// leading-zero blanking and PWM brightness.
module seven_seg_mux #(
    parameter int DIGITS   = 4,
    parameter int DEAD     = 4,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     sel,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic                  pending,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n
);
    localparam int CW = $clog2(DEAD + 2);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0]   sel_q, buf_dp, act_dp, dp_d;
    logic [4*DIGITS-1:0] buf_v, act_v, act_d;
    logic [CW-1:0]       dcnt, dcnt_d;
    logic [BRIGHT_W-1:0] pwm;
    logic [IW-1:0]       idx;
    logic [3:0]          nib;
    logic [6:0]          pat;
    logic                change, frame, valid, on, lz;

    always_comb begin
        change = sel != sel_q;
        frame  = change & sel[DIGITS-1];
        // a load coinciding with the frame boundary bypasses the pending buffer
        act_d  = frame ? (load ? value : buf_v) : act_v;
        dp_d   = frame ? (load ? dp_in : buf_dp) : act_dp;
        dcnt_d = change ? CW'(DEAD) : (dcnt != '0 ? dcnt - 1'b1 : dcnt);
        valid  = $onehot(sel);
        idx    = '0;
        for (int i = 0; i < DIGITS; i++)
            if (sel[i]) idx = IW'(i);
        nib = act_d[4*idx +: 4];
        lz  = blank_lz && idx != '0;
        for (int i = 0; i < DIGITS; i++)
            if (i >= int'(idx) && act_d[4*i +: 4] != 4'h0) lz = 1'b0;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        on = valid && dcnt_d == '0 && (&brightness || pwm < brightness);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            buf_v   <= '0;
            buf_dp  <= '0;
            act_v   <= '0;
            act_dp  <= '0;
            dcnt    <= '0;
            pwm     <= '0;
            pending <= 1'b0;
            seg_n   <= 7'h7F;
            dp_n    <= 1'b1;
            an_n    <= '1;
        end else begin
            sel_q   <= sel;
            act_v   <= act_d;
            act_dp  <= dp_d;
            dcnt    <= dcnt_d;
            pwm     <= pwm + 1'b1;
            pending <= frame ? 1'b0 : (load ? 1'b1 : pending);
            if (load) begin
                buf_v  <= value;
                buf_dp <= dp_in;
            end
            seg_n <= (valid && !lz) ? ~pat : 7'h7F;
            dp_n  <= ~(valid & dp_d[idx]);
            an_n  <= on ? ~sel : '1;
        end
    end
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed checks of two seven_seg_mux instances (no dead time / DEAD=4).
module tb_seven_seg_mux;
    logic        clk = 0, rst = 1, load = 0, blank_lz = 0;
    logic [3:0]  sel = 0, dp_in = 0, brightness = 4'hF;
    logic [15:0] value = 0;
    logic        pend0, dp0, pend4, dp4;
    logic [6:0]  seg0, seg4;
    logic [3:0]  an0, an4;
    int          compared = 0, mismatched = 0, cnt;

    always #5 clk = ~clk;

    seven_seg_mux #(.DIGITS(4), .DEAD(0), .BRIGHT_W(4)) u0 (
        .clk(clk), .rst(rst), .sel(sel), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .brightness(brightness), .pending(pend0), .seg_n(seg0),
        .dp_n(dp0), .an_n(an0));
    seven_seg_mux #(.DIGITS(4), .DEAD(4), .BRIGHT_W(4)) u4 (
        .clk(clk), .rst(rst), .sel(sel), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .brightness(brightness), .pending(pend4), .seg_n(seg4),
        .dp_n(dp4), .an_n(an4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_seg", 16'(seg0), 16'h7F);
        chk("rst_dp", 16'(dp0), 16'h1);
        chk("rst_an", 16'(an0), 16'hF);
        chk("rst_pend", 16'(pend0), 16'h0);
        rst = 0;
        // load 1234 on the frame cycle, then scan
        sel = 4'b1000; value = 16'h1234; load = 1; tick(); load = 0;
        chk("d3_seg", 16'(seg0), 16'h79); chk("d3_an", 16'(an0), 16'h7);
        chk("d3_pend", 16'(pend0), 16'h0);
        sel = 4'b0100; tick(); chk("d2_seg", 16'(seg0), 16'h24); chk("d2_an", 16'(an0), 16'hB);
        sel = 4'b0010; tick(); chk("d1_seg", 16'(seg0), 16'h30); chk("d1_an", 16'(an0), 16'hD);
        sel = 4'b0001; tick(); chk("d0_seg", 16'(seg0), 16'h19); chk("d0_an", 16'(an0), 16'hE);
        // mid-frame load waits for the next frame
        sel = 4'b0100; value = 16'hABCD; load = 1; tick(); load = 0; value = 0;
        chk("mid_pend", 16'(pend0), 16'h1); chk("mid_seg", 16'(seg0), 16'h24);
        sel = 4'b0010; tick(); chk("mid_d1", 16'(seg0), 16'h30);
        sel = 4'b0001; tick(); chk("mid_d0", 16'(seg0), 16'h19);
        sel = 4'b1000; tick(); chk("commit_seg", 16'(seg0), 16'h08);
        chk("commit_pend", 16'(pend0), 16'h0);
        sel = 4'b0100; tick(); chk("commit_d2", 16'(seg0), 16'h03);
        // load on the frame cycle itself
        sel = 4'b1000; value = 16'h8888; dp_in = 4'b1000; load = 1; tick(); load = 0;
        chk("same_pend", 16'(pend0), 16'h0); chk("same_seg", 16'(seg0), 16'h00);
        chk("same_dp", 16'(dp0), 16'h0);
        // dead time on the DEAD=4 instance
        sel = 4'b0100; tick();
        chk("dead0_an", 16'(an4), 16'hF); chk("dead0_seg", 16'(seg4), 16'h00);
        chk("nodead_an", 16'(an0), 16'hB); chk("dead0_dp", 16'(dp4), 16'h1);
        for (int i = 1; i < 4; i++) begin
            tick(); chk($sformatf("dead%0d_an", i), 16'(an4), 16'hF);
        end
        tick(); chk("dead_end_an", 16'(an4), 16'hB);
        // leading-zero blanking
        blank_lz = 1; dp_in = 0;
        sel = 4'b1000; value = 16'h0070; load = 1; tick(); load = 0;
        chk("lz_d3", 16'(seg0), 16'h7F);
        sel = 4'b0100; tick(); chk("lz_d2", 16'(seg0), 16'h7F);
        sel = 4'b0010; tick(); chk("lz_d1", 16'(seg0), 16'h78);
        sel = 4'b0001; tick(); chk("lz_d0", 16'(seg0), 16'h40);
        sel = 4'b1000; value = 16'h0000; load = 1; tick(); load = 0;
        chk("z_d3", 16'(seg0), 16'h7F);
        sel = 4'b0100; tick(); chk("z_d2", 16'(seg0), 16'h7F);
        sel = 4'b0010; tick(); chk("z_d1", 16'(seg0), 16'h7F);
        sel = 4'b0001; tick(); chk("z_d0", 16'(seg0), 16'h40); chk("z_an", 16'(an0), 16'hE);
        blank_lz = 0;
        // PWM duty
        brightness = 4'h4; cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(); if (an0 == 4'hE) cnt++;
        end
        chk("pwm4_on", 16'(cnt), 16'd4);
        brightness = 4'h0; cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(); if (an0 != 4'hF) cnt++;
        end
        chk("pwm0_on", 16'(cnt), 16'd0);
        brightness = 4'hF;
        // invalid select
        sel = 4'b0000; tick(); chk("sel0_an", 16'(an0), 16'hF); chk("sel0_seg", 16'(seg0), 16'h7F);
        sel = 4'b0110; tick(); chk("sel2_an", 16'(an0), 16'hF); chk("sel2_dp", 16'(dp0), 16'h1);
        sel = 4'b0010; tick(); chk("rec_an", 16'(an0), 16'hD); chk("rec_seg", 16'(seg0), 16'h40);
        // reset with a load pending
        sel = 4'b0100; value = 16'h1111; load = 1; tick(); load = 0;
        chk("rp_pend", 16'(pend0), 16'h1);
        rst = 1; tick();
        chk("rp_pend_clr", 16'(pend0), 16'h0); chk("rp_an", 16'(an0), 16'hF);
        chk("rp_seg", 16'(seg0), 16'h7F);
        rst = 0; sel = 4'b1000; tick();
        chk("rp_discard", 16'(seg0), 16'h40); chk("rp_discard_pend", 16'(pend0), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
